// File: rtl/pc_sequencer_if.sv
// Next-PC controller bundle: redirect/stall/debug controls in, PC and status out.
// Latency: pure wiring, no storage.
// Backpressure: none here; stall is carried as an ordinary control input.
//
// Signals:
//   stall, branch_taken, jump, target, halt_req, resume  -> into the sequencer
//   pc_out, pc_plus4, fetch_valid, state, epc, trap, retired <- from the sequencer
// Modports: slave = the sequencer itself, master = whatever drives it (core / bench).
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic            jump;
  logic [XLEN-1:0] target;
  logic            halt_req;
  logic            resume;

  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic [1:0]      state;
  logic [XLEN-1:0] epc;
  logic            trap;
  logic [XLEN-1:0] retired;

  modport slave (
    input  stall, branch_taken, jump, target, halt_req, resume,
    output pc_out, pc_plus4, fetch_valid, state, epc, trap, retired
  );

  modport master (
    output stall, branch_taken, jump, target, halt_req, resume,
    input  pc_out, pc_plus4, fetch_valid, state, epc, trap, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the architectural PC, retired count and halt/trap state.
// Latency: PC and state update on each rising edge; pc_plus4 and trap are combinational.
// Backpressure: stall holds PC and retired count; HALT holds until resume.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - pc_sequencer_if.slave: stall, branch_taken, jump, target, halt_req, resume in;
//            pc_out, pc_plus4, fetch_valid, state, epc, trap, retired out
// Build option: define PC_SEQ_MISALIGN_TRAP_EN to trap on redirects whose target is not
//   word aligned. Without it the target's low two bits are cleared and the redirect retires.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP_EN = 1'b1;
`else
  localparam bit MISALIGN_TRAP_EN = 1'b0;
`endif

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  localparam logic [1:0] ST_TRAP = 2'b11;

  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ONE         = XLEN'(1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

  logic [1:0]      state_q,   state_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] epc_q,     epc_d;
  logic [XLEN-1:0] retired_q, retired_d;

  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic            misaligned;

  assign pc_plus4   = pc_q + INSTR_BYTES;
  assign redirect   = bus.branch_taken | bus.jump;
  assign misaligned = |bus.target[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    retired_d = retired_q;

    case (state_q)
      ST_BOOT: begin
        // First fetch happens at RESET_VEC on the following cycle.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt_req) begin
            // EBREAK retires but the PC stays on it; resume restarts after it.
            epc_d     = pc_q;
            state_d   = ST_HALT;
            retired_d = retired_q + ONE;
          end else if (redirect) begin
            if (MISALIGN_TRAP_EN && misaligned) begin
              // Faulting redirect does not retire.
              epc_d   = pc_q;
              pc_d    = TRAP_VEC;
              state_d = ST_TRAP;
            end else begin
              // Low bits are already zero when trapping is enabled; otherwise force alignment.
              pc_d      = bus.target & ALIGN_MASK;
              retired_d = retired_q + ONE;
            end
          end else begin
            pc_d      = pc_plus4;
            retired_d = retired_q + ONE;
          end
        end
      end

      ST_HALT: begin
        if (bus.resume) begin
          pc_d    = epc_q + INSTR_BYTES;
          state_d = ST_RUN;
        end
      end

      ST_TRAP: begin
        // PC was loaded with TRAP_VEC on the trapping edge; just resume fetching.
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == ST_RUN);
  assign bus.state       = state_q;
  assign bus.epc         = epc_q;
  assign bus.trap        = MISALIGN_TRAP_EN && (state_q == ST_TRAP);
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of per-cycle inputs and expected outputs,
// plus a hand-written asynchronous reset sequence taken from HALT.
// Expected values depend on whether PC_SEQ_MISALIGN_TRAP_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;
  localparam logic [1:0] S_TRAP = 2'b11;

  logic clk;
  logic reset;

  pc_sequencer_if #(.XLEN(32)) bus ();

  pc_sequencer #(
    .XLEN     (32),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic        halt;
    logic        res;
    logic [31:0] exp_pc;
    logic [1:0]  exp_state;
    logic        exp_fv;
    logic [31:0] exp_epc;
    logic        exp_trap;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input logic st, input logic br, input logic jp, input logic [31:0] tgt,
                     input logic hr, input logic rs, input logic [31:0] pc,
                     input logic [1:0] s, input logic fv, input logic [31:0] epc,
                     input logic tr, input logic [31:0] ret);
    vec_t v;
    v.stall = st; v.br = br; v.jmp = jp; v.tgt = tgt; v.halt = hr; v.res = rs;
    v.exp_pc = pc; v.exp_state = s; v.exp_fv = fv; v.exp_epc = epc;
    v.exp_trap = tr; v.exp_ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [1:0] s,
                         input logic fv, input logic [31:0] epc, input logic tr,
                         input logic [31:0] ret);
    chk({tag, ".pc_out"},      bus.pc_out,             pc);
    chk({tag, ".pc_plus4"},    bus.pc_plus4,           pc + 32'd4);
    chk({tag, ".state"},       {30'd0, bus.state},     {30'd0, s});
    chk({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    chk({tag, ".epc"},         bus.epc,                epc);
    chk({tag, ".trap"},        {31'd0, bus.trap},      {31'd0, tr});
    chk({tag, ".retired"},     bus.retired,            ret);
  endtask

  task automatic drive(input logic st, input logic br, input logic jp, input logic [31:0] tgt,
                       input logic hr, input logic rs);
    bus.stall = st; bus.branch_taken = br; bus.jump = jp;
    bus.target = tgt; bus.halt_req = hr; bus.resume = rs;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // stall br jmp target halt res | pc state fv epc trap retired
    add(0,0,0,32'h0,0,0,          32'h00, S_RUN, 1, 32'h0, 0, 0);   // BOOT -> RUN, first fetch at 0
    add(0,0,0,32'h0,0,0,          32'h04, S_RUN, 1, 32'h0, 0, 1);
    add(0,0,0,32'h0,0,0,          32'h08, S_RUN, 1, 32'h0, 0, 2);
    add(0,0,0,32'h0,0,0,          32'h0C, S_RUN, 1, 32'h0, 0, 3);
    add(0,0,1,32'h08,0,0,         32'h08, S_RUN, 1, 32'h0, 0, 4);   // jump back to 8
    add(1,0,1,32'h40,0,0,         32'h08, S_RUN, 1, 32'h0, 0, 4);   // stall wins over jump
    add(1,0,1,32'h40,0,0,         32'h08, S_RUN, 1, 32'h0, 0, 4);
    add(1,0,1,32'h40,1,0,         32'h08, S_RUN, 1, 32'h0, 0, 4);   // stall also masks halt_req
    add(0,0,1,32'h40,0,0,         32'h40, S_RUN, 1, 32'h0, 0, 5);   // released -> redirect
    add(0,0,1,32'h10,0,0,         32'h10, S_RUN, 1, 32'h0, 0, 6);
    add(0,1,0,32'h20,0,0,         32'h20, S_RUN, 1, 32'h0, 0, 7);   // branch taken
    add(0,1,1,32'h24,0,0,         32'h24, S_RUN, 1, 32'h0, 0, 8);   // branch+jump single redirect
    add(0,0,1,32'h60,1,0,         32'h24, S_HALT, 0, 32'h24, 0, 9); // halt beats jump
    add(0,0,1,32'h80,0,0,         32'h24, S_HALT, 0, 32'h24, 0, 9); // ignored in HALT
    add(0,0,0,32'h0,1,0,          32'h24, S_HALT, 0, 32'h24, 0, 9);
    add(1,1,0,32'h80,0,0,         32'h24, S_HALT, 0, 32'h24, 0, 9);
    add(0,1,0,32'h84,0,0,         32'h24, S_HALT, 0, 32'h24, 0, 9);
    add(0,0,0,32'h0,0,0,          32'h24, S_HALT, 0, 32'h24, 0, 9);
    add(0,0,0,32'h0,0,1,          32'h28, S_RUN, 1, 32'h24, 0, 9);  // resume -> epc+4
    add(0,0,0,32'h0,0,1,          32'h2C, S_RUN, 1, 32'h24, 0, 10); // resume ignored in RUN
    add(0,0,0,32'h0,0,0,          32'h30, S_RUN, 1, 32'h24, 0, 11);
    // misaligned jump to 0x42 at pc 0x30
    add(0,0,1,32'h42,0,0, TE ? 32'h100 : 32'h40, TE ? S_TRAP : S_RUN, TE ? 1'b0 : 1'b1,
        TE ? 32'h30 : 32'h24, TE, TE ? 32'd11 : 32'd12);
    add(0,0,0,32'h0,0,0,  TE ? 32'h100 : 32'h44, S_RUN, 1, TE ? 32'h30 : 32'h24, 0,
        TE ? 32'd11 : 32'd13);
    add(0,0,0,32'h0,0,0,  TE ? 32'h104 : 32'h48, S_RUN, 1, TE ? 32'h30 : 32'h24, 0,
        TE ? 32'd12 : 32'd14);
    add(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, S_RUN, 1, TE ? 32'h30 : 32'h24, 0,
        TE ? 32'd13 : 32'd15);
    add(0,0,0,32'h0,0,0,  32'h0, S_RUN, 1, TE ? 32'h30 : 32'h24, 0, TE ? 32'd14 : 32'd16); // wrap
    add(0,0,0,32'h0,0,0,  32'h4, S_RUN, 1, TE ? 32'h30 : 32'h24, 0, TE ? 32'd15 : 32'd17);
    add(0,0,0,32'h0,1,0,  32'h4, S_HALT, 0, 32'h4, 0, TE ? 32'd16 : 32'd18);

    // Reset held low across an edge, then released between edges.
    #12;
    chk_all("reset_hold", 32'h0, S_BOOT, 1'b0, 32'h0, 1'b0, 32'h0);
    #10 reset = 1'b1;
    #1;
    chk_all("boot", 32'h0, S_BOOT, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].tgt, vecs[i].halt, vecs[i].res);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_state, vecs[i].exp_fv,
              vecs[i].exp_epc, vecs[i].exp_trap, vecs[i].exp_ret);
    end

    // Asynchronous reset while in HALT takes effect before the next edge.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, S_BOOT, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("reset_edge", 32'h0, S_BOOT, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reboot_run", 32'h0, S_RUN, 1'b1, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("reboot_adv", 32'h4, S_RUN, 1'b1, 32'h0, 1'b0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
